sliding_sumsq_window: RTL
=========================

Name: sliding_sumsq_window

Overview:
- Parametrised running sum of squares over the last WIN input samples: y[n] = y[n-1] + x[n]^2 - x[n-WIN]^2.
- Keeps its own sample delay line and accumulator, so the caller no longer supplies y_prev or x[n-WIN].
- Adds a valid handshake, a fill counter and a synchronous clear.
- Sits in the sample datapath, feeding energy/threshold logic downstream.

Parameters:
- DATA_W, 4, unsigned input sample width (>=1).
- WIN, 4, window length in samples (>=2).
- ACC_W, localparam = 2*DATA_W + clog2(WIN), accumulator/output width; never overflows.
- CNT_W, localparam = clog2(WIN+1), fill counter width.

Ports:
- clock_in  input  1  sole clock, all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- clear_in  input  1  synchronous window flush, active-high.
- in_valid  input  1  in_data is a new sample this cycle.
- in_data  input  DATA_W  unsigned sample.
- out_valid  output  1  one-cycle pulse; out_sum updated.
- out_sum  output  ACC_W  sum of squares of the last min(count,WIN) samples.
- window_full  output  1  high once WIN samples have been accepted since reset/clear.
- sample_count  output  CNT_W  accepted samples, saturates at WIN.

Behaviour:
- Reset (reset_in=1 at a clock edge): out_sum=0, out_valid=0, window_full=0, sample_count=0, write pointer=0, accumulator=0. Delay-line contents are not reset; they are don't-care because of the fill-count gating below. reset_in overrides clear_in and in_valid.
- Storage: circular buffer of WIN x DATA_W registers with write pointer wptr in 0..WIN-1. wptr wraps WIN-1 -> 0; for non-power-of-2 WIN, wrap by compare, not by truncation.
- Accept: in_valid=1 and no reset/clear.
  - old = buf[wptr] if sample_count==WIN, else 0.
  - acc_next = acc + in_data^2 - old^2, computed at ACC_W width and unsigned.
  - The difference form (x-old)*(x+old) is permitted if sign-extended correctly; the result must be bit-exact to the sum form.
  - buf[wptr] <= in_data; wptr advances; sample_count increments, saturating at WIN.
- Latency: 1 cycle. out_sum and out_valid register on the edge after the accepting edge. out_valid is high exactly one cycle per accepted sample. Back-to-back valids give back-to-back out_valid.
- No valid: all state holds, out_sum holds, out_valid=0.
- window_full = (sample_count==WIN), registered in the same cycle as sample_count.
- Clear (clear_in=1, reset_in=0):
  - acc, out_sum, sample_count, wptr and window_full go to 0; out_valid goes to 0.
  - An in_valid sample in the same cycle is discarded and produces no out_valid.
  - The next accepted sample restarts the window as sample #1.
- No backpressure: every valid sample is consumed; downstream must take out_sum on out_valid.
- Bound: acc <= WIN*(2^DATA_W-1)^2 < 2^ACC_W, so no saturation logic is needed.

Optional Feature:
- Macro SUMSQ_MEAN_OUT_EN.
- Defined: adds output out_mean [2*DATA_W] = out_sum >> log2(WIN), registered alongside out_sum with the same latency. Reset and clear set it to 0. During fill it still divides by WIN (zero-padded mean). WIN not a power of 2 is an elaboration-time error ($error in a generate check).
- Undefined: port and logic are absent; the block behaves exactly as above.

Test Plan:
- Defaults (DATA_W=4, WIN=4). Reset, then contiguous valid samples 1,2,3,3,3,1,2,2,1 -> out_sum 1,5,14,23,31,28,23,18,10. window_full rises with the 4th out_valid. sample_count goes 1,2,3,4,4,... out_valid is high for 9 consecutive cycles.
- Max value: 8 valid samples of 15 -> out_sum 225,450,675,900,900,900,900,900, with no wrap in the 10-bit output.
- Gapped valid: samples 1,2,3 with 2 idle cycles between each -> out_sum 1,5,14, held through the idle cycles. out_valid pulses only 1 cycle after each valid.
- Clear mid-stream: after 1,2,3,3,3 (out_sum=31), assert clear_in together with in_valid, data=7 -> 7 dropped, out_sum=0, window_full=0. Then 2,2 -> out_sum 4,8.
- Reset mid-operation: after 5 samples, pulse reset_in concurrently with in_valid -> all outputs 0 and the sample ignored. Then 1,2,3,3,3 reproduces 1,5,14,23,31 (stale buffer has no effect).
- WIN=3, DATA_W=8 (non-power-of-2 wrap): samples 10,20,30,40 -> out_sum 100,500,1400,2900. With SUMSQ_MEAN_OUT_EN defined at WIN=4 and the first test's stream, out_mean = 0,1,3,5,7,7,5,4,2.

Source files
------------

// File: rtl/sliding_sumsq_window.sv
// Running sum of squares over the last WIN unsigned samples.
// Keeps its own circular sample buffer and accumulator; the output is
// registered one edge after the accepting edge, with a fill counter,
// a window-full flag and a synchronous clear.
// Optional feature macro: SUMSQ_MEAN_OUT_EN adds out_mean = out_sum >> log2(WIN)
// (WIN must then be a power of two).
module sliding_sumsq_window #(
   parameter  int DATA_W = 4,
   parameter  int WIN    = 4,
   localparam int ACC_W  = 2*DATA_W + $clog2(WIN),
   localparam int CNT_W  = $clog2(WIN+1)
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              clear_in,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_sum,
`ifdef SUMSQ_MEAN_OUT_EN
   output logic [2*DATA_W-1:0] out_mean,
`endif
   output logic              window_full,
   output logic [CNT_W-1:0]  sample_count
);

   localparam int PTR_W = $clog2(WIN);

   logic [DATA_W-1:0] buf_q [WIN];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  sq_new, sq_old;
   logic [DATA_W-1:0] old_sample;
   logic              full_q, full_d;
   logic              valid_q;
   logic              accept;

   // Next-state for an accepted sample: evict the oldest sample once the window is full
   always_comb begin
      accept     = in_valid && !clear_in && !reset_in;
      old_sample = full_q ? buf_q[wptr_q] : '0;
      sq_new     = ACC_W'(in_data) * ACC_W'(in_data);
      sq_old     = ACC_W'(old_sample) * ACC_W'(old_sample);
      // Never underflows: sq_old is already part of acc_q when the window is full
      acc_d      = acc_q + sq_new - sq_old;
      wptr_d     = (wptr_q == PTR_W'(WIN-1)) ? '0 : wptr_q + PTR_W'(1);
      cnt_d      = (cnt_q == CNT_W'(WIN)) ? cnt_q : cnt_q + CNT_W'(1);
      full_d     = (cnt_d == CNT_W'(WIN));
   end

   // Control and accumulator state; reset wins over clear, clear drops a same-cycle sample
   always_ff @(posedge clock_in) begin
      if (reset_in || clear_in) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         full_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (in_valid) begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         full_q  <= full_d;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   // Sample delay line; contents are never reset because the fill count masks stale entries
   always_ff @(posedge clock_in) begin
      if (accept) begin
         buf_q[wptr_q] <= in_data;
      end
   end

   assign out_valid    = valid_q;
   assign out_sum      = acc_q;
   assign window_full  = full_q;
   assign sample_count = cnt_q;

`ifdef SUMSQ_MEAN_OUT_EN
   logic [2*DATA_W-1:0] mean_q, mean_d;

   if ((1 << $clog2(WIN)) != WIN) begin : g_win_pow2_chk
      $error("sliding_sumsq_window: WIN must be a power of two when out_mean is enabled");
   end

   // Zero-padded mean derived from the same next accumulator value as out_sum
   always_comb begin
      mean_d = (2*DATA_W)'(acc_d >> $clog2(WIN));
   end

   // Mean register, updated in lockstep with the accumulator
   always_ff @(posedge clock_in) begin
      if (reset_in || clear_in) begin
         mean_q <= '0;
      end else if (in_valid) begin
         mean_q <= mean_d;
      end
   end

   assign out_mean = mean_q;
`endif

endmodule
